// File: rtl/mem_server_if.sv
// Request/response bundle between the fetch unit and mem_server.
// The master issues reads and stores; the slave returns registered data.
interface mem_server_if;
    logic [3:0]  adr;
    logic        giveC;
    logic        giveD;
    logic        write_data;
    logic [15:0] com;
    logic [3:0]  data_t;
    logic        dv;
    logic        busy;
    logic        err;
    logic        wr_full;

    modport master (
        output adr, giveC, giveD, write_data,
        input  com, data_t, dv, busy, err, wr_full
    );

    modport slave (
        input  adr, giveC, giveD, write_data,
        output com, data_t, dv, busy, err, wr_full
    );
endinterface

// File: rtl/mem_server.sv
// Command ROM + data RAM server with programmable read latency, busy/err flags
// and a sequential, non-wrapping write region.
//
// state | meaning
// IDLE  | accepting requests; with LATENCY==1 responds at the sampling edge
// WAIT  | request latched, cnt counting down to the response edge (cnt==1)
module mem_server #(
    parameter int          CMD_DEPTH  = 2,
    parameter int          DATA_DEPTH = 7,
    parameter int          WR_BASE    = 4,
    parameter int          LATENCY    = 1,
    parameter logic [15:0] CMD_INIT  [CMD_DEPTH]  = '{16'h0046, 16'h0247},
    parameter logic [3:0]  DATA_INIT [DATA_DEPTH] = '{4'd0, 4'd0, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0}
) (
    input  logic         clk,
    input  logic         rst,
    mem_server_if.slave  bus
);

    localparam logic [4:0] CMD_LIM   = 5'(CMD_DEPTH);
    localparam logic [4:0] DATA_LIM  = 5'(DATA_DEPTH);
    localparam logic [4:0] WR_BASE_L = 5'(WR_BASE);
    localparam logic [4:0] WR_LAST   = 5'(DATA_DEPTH - 1);
    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  lat_adr, lat_adr_nxt;
    logic        kind_c, kind_c_nxt;
    logic        kind_d, kind_d_nxt;

    logic        fire;
    logic [3:0]  fire_adr;
    logic        fire_c;
    logic        fire_d;
    logic [15:0] rd_com;
    logic [3:0]  rd_data;
    logic        rd_err;

    logic [3:0]  data_mem [DATA_DEPTH];
    logic [4:0]  wptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            lat_adr <= 4'd0;
            kind_c  <= 1'b0;
            kind_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lat_adr <= lat_adr_nxt;
            kind_c  <= kind_c_nxt;
            kind_d  <= kind_d_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lat_adr_nxt = lat_adr;
        kind_c_nxt  = kind_c;
        kind_d_nxt  = kind_d;
        fire        = 1'b0;
        fire_adr    = lat_adr;
        fire_c      = kind_c;
        fire_d      = kind_d;
        case (state)
            IDLE: begin
                if (bus.giveC || bus.giveD) begin
                    lat_adr_nxt = bus.adr;
                    kind_c_nxt  = bus.giveC;
                    kind_d_nxt  = bus.giveD;
                    if (LATENCY == 1) begin
                        fire     = 1'b1;
                        fire_adr = bus.adr;
                        fire_c   = bus.giveC;
                        fire_d   = bus.giveD;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end
                cnt_nxt = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loop-based lookups return 0 for out-of-range addresses without
    // ever indexing past the end of either memory.
    always_comb begin
        rd_com  = 16'h0000;
        rd_data = 4'h0;
        for (int i = 0; i < CMD_DEPTH; i++) begin
            if ({1'b0, fire_adr} == 5'(i)) rd_com = CMD_INIT[i];
        end
        for (int i = 0; i < DATA_DEPTH; i++) begin
            if ({1'b0, fire_adr} == 5'(i)) rd_data = data_mem[i];
        end
        rd_err = (fire_c && ({1'b0, fire_adr} >= CMD_LIM)) ||
                 (fire_d && ({1'b0, fire_adr} >= DATA_LIM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dv     <= 1'b0;
            bus.err    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.com    <= 16'h0000;
            bus.data_t <= 4'h0;
        end else begin
            bus.dv   <= fire;
            bus.err  <= fire && rd_err;
            bus.busy <= (state_nxt == WAIT);
            if (fire && fire_c) bus.com    <= rd_com;
            if (fire && fire_d) bus.data_t <= rd_data;
        end
    end

    // Stores run independently of the read FSM; reads see pre-store data.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_mem    <= DATA_INIT;
            wptr        <= WR_BASE_L;
            bus.wr_full <= 1'b0;
        end else if (bus.write_data && !bus.wr_full) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                if (wptr == 5'(i)) data_mem[i] <= bus.adr;
            end
            if (wptr == WR_LAST) bus.wr_full <= 1'b1;
            else                 wptr        <= wptr + 5'd1;
        end
    end

endmodule

// File: tb/tb_mem_server.sv
// Directed bench for mem_server: three instances at LATENCY 1, 3 and 4
// sharing one clock and reset, each driven through its own interface.
module tb_mem_server;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_server_if u1 ();
    mem_server_if u3 ();
    mem_server_if u4 ();

    mem_server #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(u1.slave));
    mem_server #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(u3.slave));
    mem_server #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(u4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (u1.com !== 16'h0000) begin miscompares++; $display("FAIL rst_com: got %h expected 0000", u1.com); end
        vectors++; if (u1.data_t !== 4'h0) begin miscompares++; $display("FAIL rst_data: got %h expected 0", u1.data_t); end
        vectors++; if (u1.dv !== 1'b0 || u1.err !== 1'b0) begin miscompares++; $display("FAIL rst_dv_err: got %b%b expected 00", u1.dv, u1.err); end
        vectors++; if (u3.busy !== 1'b0 || u1.wr_full !== 1'b0) begin miscompares++; $display("FAIL rst_busy_full: got %b%b expected 00", u3.busy, u1.wr_full); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_l1_cmd();
        u1.giveC = 1'b1; u1.adr = 4'd1;
        tick();
        u1.giveC = 1'b0;
        vectors++; if (u1.dv !== 1'b1) begin miscompares++; $display("FAIL l1_dv: got %b expected 1", u1.dv); end
        vectors++; if (u1.com !== 16'h0247) begin miscompares++; $display("FAIL l1_com: got %h expected 0247", u1.com); end
        vectors++; if (u1.err !== 1'b0) begin miscompares++; $display("FAIL l1_err: got %b expected 0", u1.err); end
        tick();
        vectors++; if (u1.dv !== 1'b0) begin miscompares++; $display("FAIL l1_dv_pulse: got %b expected 0", u1.dv); end
        vectors++; if (u1.com !== 16'h0247) begin miscompares++; $display("FAIL l1_com_hold: got %h expected 0247", u1.com); end
    endtask

    task automatic test_latency3();
        u3.giveD = 1'b1; u3.adr = 4'd2;
        tick();
        vectors++; if (u3.busy !== 1'b1 || u3.dv !== 1'b0) begin miscompares++; $display("FAIL l3_wait1: got busy=%b dv=%b expected 1 0", u3.busy, u3.dv); end
        u3.giveD = 1'b0; u3.giveC = 1'b1; u3.adr = 4'd0;
        tick();
        u3.giveC = 1'b0;
        vectors++; if (u3.busy !== 1'b1 || u3.dv !== 1'b0) begin miscompares++; $display("FAIL l3_wait2: got busy=%b dv=%b expected 1 0", u3.busy, u3.dv); end
        tick();
        vectors++; if (u3.dv !== 1'b1 || u3.busy !== 1'b0) begin miscompares++; $display("FAIL l3_resp: got dv=%b busy=%b expected 1 0", u3.dv, u3.busy); end
        vectors++; if (u3.data_t !== 4'd3) begin miscompares++; $display("FAIL l3_data: got %h expected 3", u3.data_t); end
        tick();
        vectors++; if (u3.dv !== 1'b0) begin miscompares++; $display("FAIL l3_dropped_dv: got %b expected 0", u3.dv); end
        vectors++; if (u3.com !== 16'h0000) begin miscompares++; $display("FAIL l3_dropped_com: got %h expected 0000", u3.com); end
    endtask

    task automatic test_both();
        u1.giveD = 1'b1; u1.adr = 4'd3;
        tick();
        vectors++; if (u1.data_t !== 4'd1) begin miscompares++; $display("FAIL both_pre: got %h expected 1", u1.data_t); end
        u1.giveC = 1'b1; u1.adr = 4'd0;
        tick();
        u1.giveC = 1'b0; u1.giveD = 1'b0;
        vectors++; if (u1.dv !== 1'b1) begin miscompares++; $display("FAIL both_dv: got %b expected 1", u1.dv); end
        vectors++; if (u1.com !== 16'h0046) begin miscompares++; $display("FAIL both_com: got %h expected 0046", u1.com); end
        vectors++; if (u1.data_t !== 4'd0) begin miscompares++; $display("FAIL both_data: got %h expected 0", u1.data_t); end
        tick();
        vectors++; if (u1.dv !== 1'b0) begin miscompares++; $display("FAIL both_single: got %b expected 0", u1.dv); end
    endtask

    task automatic test_out_of_range();
        u1.giveD = 1'b1; u1.adr = 4'd3;
        tick();
        vectors++; if (u1.data_t !== 4'd1 || u1.err !== 1'b0) begin miscompares++; $display("FAIL oor_pre: got data=%h err=%b expected 1 0", u1.data_t, u1.err); end
        u1.adr = 4'd9;
        tick();
        vectors++; if (u1.dv !== 1'b1 || u1.err !== 1'b1) begin miscompares++; $display("FAIL oor_d_flags: got dv=%b err=%b expected 1 1", u1.dv, u1.err); end
        vectors++; if (u1.data_t !== 4'd0) begin miscompares++; $display("FAIL oor_d_data: got %h expected 0", u1.data_t); end
        u1.giveD = 1'b0; u1.giveC = 1'b1; u1.adr = 4'd2;
        tick();
        u1.giveC = 1'b0;
        vectors++; if (u1.dv !== 1'b1 || u1.err !== 1'b1) begin miscompares++; $display("FAIL oor_c_flags: got dv=%b err=%b expected 1 1", u1.dv, u1.err); end
        vectors++; if (u1.com !== 16'h0000) begin miscompares++; $display("FAIL oor_c_com: got %h expected 0000", u1.com); end
        tick();
        vectors++; if (u1.err !== 1'b0 || u1.dv !== 1'b0) begin miscompares++; $display("FAIL oor_clear: got err=%b dv=%b expected 0 0", u1.err, u1.dv); end
    endtask

    task automatic test_write();
        logic [3:0] wval [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
        logic [3:0] radr [3] = '{4'd4, 4'd5, 4'd6};
        logic [3:0] rexp [3] = '{4'd5, 4'd6, 4'd7};
        for (int k = 0; k < 4; k++) begin
            u1.write_data = 1'b1; u1.adr = wval[k];
            tick();
            vectors++; if (u1.wr_full !== (k >= 2)) begin miscompares++; $display("FAIL wr_full_%0d: got %b expected %b", k, u1.wr_full, (k >= 2)); end
        end
        u1.write_data = 1'b0;
        for (int k = 0; k < 3; k++) begin
            u1.giveD = 1'b1; u1.adr = radr[k];
            tick();
            vectors++; if (u1.data_t !== rexp[k]) begin miscompares++; $display("FAIL wr_read_%0d: got %h expected %h", radr[k], u1.data_t, rexp[k]); end
        end
        u1.giveD = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] radr [3] = '{4'd4, 4'd3, 4'd4};
        logic [3:0] rexp [3] = '{4'd9, 4'd1, 4'd0};
        int n;
        u4.write_data = 1'b1; u4.adr = 4'd9;
        tick();
        u4.write_data = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                u4.giveD = 1'b1; u4.adr = 4'd4;
                tick();
                u4.giveD = 1'b0;
                vectors++; if (u4.busy !== 1'b1) begin miscompares++; $display("FAIL rw_busy: got %b expected 1", u4.busy); end
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                vectors++; if (u4.busy !== 1'b0 || u4.dv !== 1'b0) begin miscompares++; $display("FAIL rw_after_rst: got busy=%b dv=%b expected 0 0", u4.busy, u4.dv); end
                for (int j = 0; j < 6; j++) begin
                    tick();
                    vectors++; if (u4.dv !== 1'b0) begin miscompares++; $display("FAIL rw_no_dv_%0d: got %b expected 0", j, u4.dv); end
                end
            end
            u4.giveD = 1'b1; u4.adr = radr[k];
            tick();
            u4.giveD = 1'b0;
            n = 1;
            while (u4.dv !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            vectors++; if (n != 4) begin miscompares++; $display("FAIL l4_latency_%0d: got %0d cycles expected 4", k, n); end
            vectors++; if (u4.data_t !== rexp[k]) begin miscompares++; $display("FAIL l4_data_%0d: got %h expected %h", k, u4.data_t, rexp[k]); end
            tick();
        end
    endtask

    initial begin
        u1.adr = 4'd0; u1.giveC = 1'b0; u1.giveD = 1'b0; u1.write_data = 1'b0;
        u3.adr = 4'd0; u3.giveC = 1'b0; u3.giveD = 1'b0; u3.write_data = 1'b0;
        u4.adr = 4'd0; u4.giveC = 1'b0; u4.giveD = 1'b0; u4.write_data = 1'b0;
        test_reset();
        test_l1_cmd();
        test_latency3();
        test_both();
        test_out_of_range();
        test_write();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
